// File: rtl/alu_div_ctrl_pkg.sv
// Shared definitions for the divide controller: data width, op-field bit
// positions, FSM state encoding and the word-result sign-extension helper.
package alu_div_ctrl_pkg;

  localparam int DATA_W        = 64;
  localparam int OP_W          = 3;
  localparam int OP_REM_BIT    = 0;
  localparam int OP_SIGNED_BIT = 1;
  localparam int OP_WORD_BIT   = 2;

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_IDLE   = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESP   = 3'd4,
    ST_DRAIN  = 3'd5
  } state_t;

  // W-type ops always return bit 31 replicated into the upper half.
  function automatic logic [DATA_W-1:0] sext_word(input logic [DATA_W-1:0] v);
    return {{(DATA_W-32){v[31]}}, v[31:0]};
  endfunction

endpackage

// File: rtl/alu_div_ctrl_if.sv
// Request, result and slow-divider signals of the divide controller.
interface alu_div_ctrl_if;
  import alu_div_ctrl_pkg::*;

  logic              flush_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic              op_rem_i;
  logic              op_signed_i;
  logic              op_word_i;
  logic [DATA_W-1:0] rs1_i;
  logic [DATA_W-1:0] rs2_i;
  logic              res_valid_o;
  logic              res_ready_i;
  logic [DATA_W-1:0] res_data_o;
  logic              div_valid_o;
  logic              div_signed_o;
  logic              div32_o;
  logic [DATA_W-1:0] dividend_o;
  logic [DATA_W-1:0] divisor_o;
  logic              div_ready_i;
  logic [DATA_W-1:0] div_quot_i;
  logic [DATA_W-1:0] div_rem_i;

  modport slave (
    input  flush_i, in_valid_i, op_rem_i, op_signed_i, op_word_i, rs1_i, rs2_i,
    input  res_ready_i, div_ready_i, div_quot_i, div_rem_i,
    output in_ready_o, res_valid_o, res_data_o,
    output div_valid_o, div_signed_o, div32_o, dividend_o, divisor_o
  );

  modport master (
    output flush_i, in_valid_i, op_rem_i, op_signed_i, op_word_i, rs1_i, rs2_i,
    output res_ready_i, div_ready_i, div_quot_i, div_rem_i,
    input  in_ready_o, res_valid_o, res_data_o,
    input  div_valid_o, div_signed_o, div32_o, dividend_o, divisor_o
  );

endinterface

// File: rtl/alu_div_ctrl_div_special_case.sv
// Combinational RISC-V divide corner-case detection (div-by-zero, signed
// overflow) and final result formation for both bypassed and divider results.
module div_special_case
  import alu_div_ctrl_pkg::*;
(
  input  logic [OP_W-1:0]   acc_op,
  input  logic [DATA_W-1:0] acc_rs1,
  input  logic [DATA_W-1:0] acc_rs2,
  input  logic [OP_W-1:0]   held_op,
  input  logic [DATA_W-1:0] quot,
  input  logic [DATA_W-1:0] rem,
  output logic              special,
  output logic [DATA_W-1:0] special_res,
  output logic [DATA_W-1:0] div_res
);

  localparam logic signed [DATA_W-1:0] MIN_S = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [31:0]       MIN_W = {1'b1, 31'b0};

  logic              is_word;
  logic              is_signed;
  logic              div_zero;
  logic              overflow;
  logic [DATA_W-1:0] dvd;
  logic [DATA_W-1:0] sel;

  always_comb begin
    is_word   = acc_op[OP_WORD_BIT];
    is_signed = acc_op[OP_SIGNED_BIT];
    dvd       = is_word ? sext_word(acc_rs1) : acc_rs1;
    div_zero  = is_word ? (acc_rs2[31:0] == 32'd0) : (acc_rs2 == '0);
    // Most-negative / -1 is the only signed quotient that does not fit.
    if (is_word) begin
      overflow = is_signed && ($signed(acc_rs1[31:0]) == MIN_W) && (acc_rs2[31:0] == '1);
    end else begin
      overflow = is_signed && ($signed(acc_rs1) == MIN_S) && (acc_rs2 == '1);
    end
    special     = div_zero | overflow;
    special_res = '0;
    if (div_zero) begin
      special_res = acc_op[OP_REM_BIT] ? dvd : '1;
    end else if (overflow) begin
      special_res = acc_op[OP_REM_BIT] ? '0 : dvd;
    end

    sel     = held_op[OP_REM_BIT] ? rem : quot;
    div_res = held_op[OP_WORD_BIT] ? sext_word(sel) : sel;
  end

endmodule

// File: rtl/alu_div_ctrl.sv
// Sequencing FSM between the EX stage and the multi-cycle divider: accepts an
// op, bypasses RISC-V corner cases, launches the divider and returns results.
module alu_div_ctrl
  import alu_div_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  alu_div_ctrl_if.slave bus
);

  state_t            state_q;
  state_t            state_d;
  logic [OP_W-1:0]   acc_op;
  logic [OP_W-1:0]   op_p1;
  logic [DATA_W-1:0] dividend_p1;
  logic [DATA_W-1:0] divisor_p1;
  logic [DATA_W-1:0] res_p1;
  logic              accept;
  logic              special;
  logic [DATA_W-1:0] special_res;
  logic [DATA_W-1:0] div_res;
  logic              capture;

  always_comb begin
    acc_op                = '0;
    acc_op[OP_REM_BIT]    = bus.op_rem_i;
    acc_op[OP_SIGNED_BIT] = bus.op_signed_i;
    acc_op[OP_WORD_BIT]   = bus.op_word_i;
  end

  div_special_case u_special (
    .acc_op      (acc_op),
    .acc_rs1     (bus.rs1_i),
    .acc_rs2     (bus.rs2_i),
    .held_op     (op_p1),
    .quot        (bus.div_quot_i),
    .rem         (bus.div_rem_i),
    .special     (special),
    .special_res (special_res),
    .div_res     (div_res)
  );

  assign bus.in_ready_o   = (state_q == ST_IDLE) && !bus.flush_i;
  assign accept           = bus.in_valid_i && bus.in_ready_o;
  assign capture          = (state_q == ST_WAIT) && bus.div_ready_i && !bus.flush_i;
  assign bus.res_valid_o  = (state_q == ST_RESP);
  assign bus.res_data_o   = res_p1;
  assign bus.div_valid_o  = (state_q == ST_LAUNCH);
  assign bus.div_signed_o = op_p1[OP_SIGNED_BIT];
  assign bus.div32_o      = op_p1[OP_WORD_BIT];
  assign bus.dividend_o   = dividend_p1;
  assign bus.divisor_o    = divisor_p1;

  // A flush in LAUNCH still lets the launch pulse go out, so DRAIN always has
  // a completion pulse to wait for.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RST:    state_d = ST_IDLE;
      ST_IDLE:   if (accept) state_d = special ? ST_RESP : ST_LAUNCH;
      ST_LAUNCH: state_d = bus.flush_i ? ST_DRAIN : ST_WAIT;
      ST_WAIT: begin
        if (bus.flush_i)          state_d = bus.div_ready_i ? ST_IDLE : ST_DRAIN;
        else if (bus.div_ready_i) state_d = ST_RESP;
      end
      ST_RESP:   if (bus.flush_i || bus.res_ready_i) state_d = ST_IDLE;
      ST_DRAIN:  if (bus.div_ready_i) state_d = ST_IDLE;
      default:   state_d = ST_RST;
    endcase
  end

  // Stage p1: accepted op/operands and the result held for writeback
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RST;
      op_p1       <= '0;
      dividend_p1 <= '0;
      divisor_p1  <= '0;
      res_p1      <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_p1       <= acc_op;
        dividend_p1 <= bus.rs1_i;
        divisor_p1  <= bus.rs2_i;
        if (special) res_p1 <= special_res;
      end
      if (capture) res_p1 <= div_res;
    end
  end

endmodule

// File: tb/tb_alu_div_ctrl.sv
// Directed bench for alu_div_ctrl; the bench plays both EX and the divider.
module tb_alu_div_ctrl;
  import alu_div_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   dv_cnt = 0;

  alu_div_ctrl_if ifc ();

  alu_div_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ifc.div_valid_o === 1'b1) dv_cnt <= dv_cnt + 1;

  task automatic drive_op(input logic r, input logic s, input logic w,
                          input logic [63:0] a, input logic [63:0] b);
    ifc.in_valid_i  = 1'b1;
    ifc.op_rem_i    = r;
    ifc.op_signed_i = s;
    ifc.op_word_i   = w;
    ifc.rs1_i       = a;
    ifc.rs2_i       = b;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (ifc.in_ready_o !== 1'b0)  begin n_bad++; $display("FAIL rst_in_ready got %b want 0", ifc.in_ready_o); end
    n_cmp++; if (ifc.res_valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_res_valid got %b want 0", ifc.res_valid_o); end
    n_cmp++; if (ifc.div_valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_div_valid got %b want 0", ifc.div_valid_o); end
    n_cmp++; if (ifc.res_data_o !== 64'd0) begin n_bad++; $display("FAIL rst_res_data got %h want 0", ifc.res_data_o); end
    n_cmp++; if (ifc.dividend_o !== 64'd0 || ifc.divisor_o !== 64'd0) begin
      n_bad++; $display("FAIL rst_operands got %h/%h want 0/0", ifc.dividend_o, ifc.divisor_o); end
    n_cmp++; if ({ifc.div_signed_o, ifc.div32_o} !== 2'b00) begin
      n_bad++; $display("FAIL rst_mode got %b%b want 00", ifc.div_signed_o, ifc.div32_o); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (ifc.in_ready_o !== 1'b0) begin n_bad++; $display("FAIL rst_state_one_cycle in_ready got %b want 0", ifc.in_ready_o); end
    @(negedge clk);
    n_cmp++; if (ifc.in_ready_o !== 1'b1) begin n_bad++; $display("FAIL rst_to_idle in_ready got %b want 1", ifc.in_ready_o); end
  endtask

  // Full divider round trip; hold = cycles res_ready_i stays low in RESP.
  task automatic test_div(input string nm, input logic r, input logic s, input logic w,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] q, input logic [63:0] rm,
                          input logic [63:0] exp, input int hold);
    int dv0;
    dv0 = dv_cnt;
    @(posedge clk); #1 drive_op(r, s, w, a, b);
    @(negedge clk);
    n_cmp++; if (ifc.in_ready_o !== 1'b1) begin n_bad++; $display("FAIL %s in_ready got %b want 1", nm, ifc.in_ready_o); end
    @(posedge clk); #1 ifc.in_valid_i = 1'b0;
    @(negedge clk);
    n_cmp++; if (ifc.div_valid_o !== 1'b1 || ifc.dividend_o !== a || ifc.divisor_o !== b ||
                 ifc.div_signed_o !== s || ifc.div32_o !== w) begin
      n_bad++; $display("FAIL %s launch got v=%b %h %h s=%b w=%b want v=1 %h %h s=%b w=%b", nm,
        ifc.div_valid_o, ifc.dividend_o, ifc.divisor_o, ifc.div_signed_o, ifc.div32_o, a, b, s, w); end
    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      n_cmp++; if (ifc.div_valid_o !== 1'b0 || ifc.res_valid_o !== 1'b0 || ifc.dividend_o !== a || ifc.divisor_o !== b) begin
        n_bad++; $display("FAIL %s wait got dv=%b rv=%b %h %h want 0 0 %h %h", nm,
          ifc.div_valid_o, ifc.res_valid_o, ifc.dividend_o, ifc.divisor_o, a, b); end
      @(posedge clk);
    end
    #1 ifc.div_ready_i = 1'b1; ifc.div_quot_i = q; ifc.div_rem_i = rm;
    @(posedge clk); #1 ifc.div_ready_i = 1'b0; ifc.div_quot_i = '0; ifc.div_rem_i = '0;
    repeat (hold) begin
      @(negedge clk);
      n_cmp++; if (ifc.res_valid_o !== 1'b1 || ifc.res_data_o !== exp) begin
        n_bad++; $display("FAIL %s hold got v=%b %h want v=1 %h", nm, ifc.res_valid_o, ifc.res_data_o, exp); end
      @(posedge clk);
    end
    @(negedge clk);
    n_cmp++; if (ifc.res_valid_o !== 1'b1 || ifc.res_data_o !== exp) begin
      n_bad++; $display("FAIL %s result got v=%b %h want v=1 %h", nm, ifc.res_valid_o, ifc.res_data_o, exp); end
    ifc.res_ready_i = 1'b1;
    ifc.in_valid_i  = 1'b1;
    #1;
    n_cmp++; if (ifc.in_ready_o !== 1'b0) begin n_bad++; $display("FAIL %s ready_during_resp got %b want 0", nm, ifc.in_ready_o); end
    @(posedge clk); #1 ifc.res_ready_i = 1'b0; ifc.in_valid_i = 1'b0;
    @(negedge clk);
    n_cmp++; if (ifc.res_valid_o !== 1'b0 || ifc.in_ready_o !== 1'b1) begin
      n_bad++; $display("FAIL %s after_hs got rv=%b rdy=%b want 0 1", nm, ifc.res_valid_o, ifc.in_ready_o); end
    n_cmp++; if (dv_cnt - dv0 !== 1) begin n_bad++; $display("FAIL %s launch_count got %0d want 1", nm, dv_cnt - dv0); end
  endtask

  task automatic test_special(input string nm, input logic r, input logic s, input logic w,
                              input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp);
    int dv0;
    dv0 = dv_cnt;
    @(posedge clk); #1 drive_op(r, s, w, a, b);
    @(posedge clk); #1 ifc.in_valid_i = 1'b0;
    @(negedge clk);
    n_cmp++; if (ifc.res_valid_o !== 1'b1 || ifc.res_data_o !== exp || ifc.div_valid_o !== 1'b0) begin
      n_bad++; $display("FAIL %s bypass got rv=%b %h dv=%b want rv=1 %h dv=0", nm,
        ifc.res_valid_o, ifc.res_data_o, ifc.div_valid_o, exp); end
    ifc.res_ready_i = 1'b1;
    @(posedge clk); #1 ifc.res_ready_i = 1'b0;
    @(negedge clk);
    n_cmp++; if (ifc.res_valid_o !== 1'b0 || dv_cnt - dv0 !== 0) begin
      n_bad++; $display("FAIL %s after_hs got rv=%b launches=%0d want 0 0", nm, ifc.res_valid_o, dv_cnt - dv0); end
  endtask

  task automatic test_flush_wait();
    @(posedge clk); #1 drive_op(1'b0, 1'b1, 1'b0, 64'd100, 64'd7);
    @(posedge clk); #1 ifc.in_valid_i = 1'b0;
    @(posedge clk); #1 ifc.flush_i = 1'b1;
    @(posedge clk); #1 ifc.flush_i = 1'b0;
    @(negedge clk);
    n_cmp++; if (ifc.res_valid_o !== 1'b0 || ifc.in_ready_o !== 1'b0) begin
      n_bad++; $display("FAIL flush_drain got rv=%b rdy=%b want 0 0", ifc.res_valid_o, ifc.in_ready_o); end
    @(posedge clk); #1 ifc.flush_i = 1'b1;
    @(posedge clk); #1 ifc.flush_i = 1'b0;
    @(negedge clk);
    n_cmp++; if (ifc.in_ready_o !== 1'b0 || ifc.res_valid_o !== 1'b0) begin
      n_bad++; $display("FAIL flush_in_drain got rdy=%b rv=%b want 0 0", ifc.in_ready_o, ifc.res_valid_o); end
    ifc.div_ready_i = 1'b1; ifc.div_quot_i = 64'hDEAD; ifc.div_rem_i = 64'hBEEF;
    @(posedge clk); #1 ifc.div_ready_i = 1'b0;
    @(negedge clk);
    n_cmp++; if (ifc.res_valid_o !== 1'b0 || ifc.in_ready_o !== 1'b1) begin
      n_bad++; $display("FAIL drain_exit got rv=%b rdy=%b want 0 1", ifc.res_valid_o, ifc.in_ready_o); end
    test_div("div_100_7", 1'b0, 1'b1, 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 64'd14, 0);
  endtask

  task automatic test_flush_misc();
    // flush coinciding with completion in WAIT
    @(posedge clk); #1 drive_op(1'b0, 1'b0, 1'b0, 64'd50, 64'd5);
    @(posedge clk); #1 ifc.in_valid_i = 1'b0;
    @(posedge clk); #1 ifc.flush_i = 1'b1; ifc.div_ready_i = 1'b1; ifc.div_quot_i = 64'd10;
    @(posedge clk); #1 ifc.flush_i = 1'b0; ifc.div_ready_i = 1'b0;
    @(negedge clk);
    n_cmp++; if (ifc.res_valid_o !== 1'b0 || ifc.in_ready_o !== 1'b1) begin
      n_bad++; $display("FAIL flush_coincide got rv=%b rdy=%b want 0 1", ifc.res_valid_o, ifc.in_ready_o); end
    // flush in IDLE blocks acceptance
    ifc.flush_i = 1'b1; drive_op(1'b0, 1'b0, 1'b0, 64'd9, 64'd3);
    #1;
    n_cmp++; if (ifc.in_ready_o !== 1'b0) begin n_bad++; $display("FAIL flush_idle in_ready got %b want 0", ifc.in_ready_o); end
    @(posedge clk); #1 ifc.flush_i = 1'b0; ifc.in_valid_i = 1'b0;
    @(negedge clk);
    n_cmp++; if (ifc.div_valid_o !== 1'b0 || ifc.in_ready_o !== 1'b1) begin
      n_bad++; $display("FAIL flush_idle_noaccept got dv=%b rdy=%b want 0 1", ifc.div_valid_o, ifc.in_ready_o); end
    // flush in RESP drops the bypass result
    @(posedge clk); #1 drive_op(1'b0, 1'b0, 1'b0, 64'd5, 64'd0);
    @(posedge clk); #1 ifc.in_valid_i = 1'b0; ifc.flush_i = 1'b1;
    @(posedge clk); #1 ifc.flush_i = 1'b0;
    @(negedge clk);
    n_cmp++; if (ifc.res_valid_o !== 1'b0 || ifc.in_ready_o !== 1'b1) begin
      n_bad++; $display("FAIL flush_resp got rv=%b rdy=%b want 0 1", ifc.res_valid_o, ifc.in_ready_o); end
  endtask

  task automatic test_reset_midop();
    @(posedge clk); #1 drive_op(1'b0, 1'b1, 1'b0, 64'd77, 64'd7);
    @(posedge clk); #1 ifc.in_valid_i = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (ifc.res_valid_o !== 1'b0 || ifc.in_ready_o !== 1'b0 || ifc.dividend_o !== 64'd0) begin
      n_bad++; $display("FAIL rst_midop got rv=%b rdy=%b dvd=%h want 0 0 0", ifc.res_valid_o, ifc.in_ready_o, ifc.dividend_o); end
    @(negedge clk);
    n_cmp++; if (ifc.in_ready_o !== 1'b1) begin n_bad++; $display("FAIL rst_midop_idle got %b want 1", ifc.in_ready_o); end
  endtask

  initial begin
    ifc.flush_i = 1'b0; ifc.in_valid_i = 1'b0; ifc.op_rem_i = 1'b0; ifc.op_signed_i = 1'b0;
    ifc.op_word_i = 1'b0; ifc.rs1_i = '0; ifc.rs2_i = '0; ifc.res_ready_i = 1'b0;
    ifc.div_ready_i = 1'b0; ifc.div_quot_i = '0; ifc.div_rem_i = '0;
    test_reset();
    test_div("div_m7_2", 1'b0, 1'b1, 1'b0, 64'hFFFFFFFFFFFFFFF9, 64'd2,
             64'hFFFFFFFFFFFFFFFD, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFD, 0);
    test_div("rem_m7_2_hold", 1'b1, 1'b1, 1'b0, 64'hFFFFFFFFFFFFFFF9, 64'd2,
             64'hFFFFFFFFFFFFFFFD, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 5);
    test_div("divuw", 1'b0, 1'b0, 1'b1, 64'h0000000080000000, 64'd1,
             64'h0000000080000000, 64'd0, 64'hFFFFFFFF80000000, 0);
    test_special("divu_by0", 1'b0, 1'b0, 1'b0, 64'd5, 64'd0, 64'hFFFFFFFFFFFFFFFF);
    test_special("remu_by0", 1'b1, 1'b0, 1'b0, 64'd5, 64'd0, 64'd5);
    test_special("div_ovf", 1'b0, 1'b1, 1'b0, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'h8000000000000000);
    test_special("remw_ovf", 1'b1, 1'b1, 1'b1, 64'h0000000080000000, 64'h00000000FFFFFFFF, 64'd0);
    test_special("remw_by0", 1'b1, 1'b1, 1'b1, 64'h0000000080000001, 64'h0000000100000000, 64'hFFFFFFFF80000001);
    test_special("divw_ovf", 1'b0, 1'b1, 1'b1, 64'h0000000080000000, 64'h00000000FFFFFFFF, 64'hFFFFFFFF80000000);
    test_flush_wait();
    test_flush_misc();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached without completing the sequence");
    $fatal(1, "timeout");
  end

endmodule
